// File: rtl/fir_tx_pkg.sv
// Shared types and sizing helpers for the filtered-sample serial transmitter.
package fir_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  localparam int DEF_OUT_W   = 16;
  localparam int DEF_BIT_DIV = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_BIT_CNT_W = cnt_w(DEF_OUT_W);
  localparam int DEF_PH_CNT_W  = cnt_w(DEF_BIT_DIV);

endpackage

// File: rtl/fir_tx_scaler.sv
// Arithmetic right shift and width reduction of one filter output sample.
// FIR_SAMPLE_TX_SATURATE_EN selects clamping instead of wrap-around truncation.
module fir_tx_scaler #(
  parameter int N     = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 10
) (
  input  logic signed [N-1:0]     i_y,
  output logic        [OUT_W-1:0] o_word
);
  import fir_tx_pkg::*;

`ifdef FIR_SAMPLE_TX_SATURATE_EN
  logic signed [N-1:0] w_s;
  logic                w_ovf;

  assign w_s = i_y >>> SHIFT;
  // Value fits only when every bit above the output sign bit matches it.
  assign w_ovf  = !((&w_s[N-1:OUT_W-1]) || !(|w_s[N-1:OUT_W-1]));
  assign o_word = w_ovf ? {w_s[N-1], {(OUT_W-1){~w_s[N-1]}}} : w_s[OUT_W-1:0];
`else
  assign o_word = OUT_W'(i_y >>> SHIFT);
`endif

endmodule

// File: rtl/fir_sample_tx.sv
// Captures a filter sample on each clk_d rising edge and shifts it out MSB-first
// with bit clock and one-bit frame sync. Build option: FIR_SAMPLE_TX_SATURATE_EN.
//
// state | meaning
// IDLE  | waiting for a sample edge, outputs low
// SHIFT | frame in progress, OUT_W bits of BIT_DIV clk cycles each
module fir_sample_tx #(
  parameter int N       = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 10,
  parameter int BIT_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                clk_d,
  input  logic signed [N-1:0] y_in,
  input  logic                ovr_clr,
  output logic                sck,
  output logic                ws,
  output logic                sd,
  output logic                busy,
  output logic                overrun
);
  import fir_tx_pkg::*;

  localparam int BC_W = cnt_w(OUT_W);
  localparam int PH_W = cnt_w(BIT_DIV);
  localparam logic [BC_W-1:0] BIT_FIRST = BC_W'(OUT_W - 1);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(BIT_DIV / 2);

  tx_state_e        r_state;
  logic             r_clk_d_q;
  logic [OUT_W-1:0] r_sr;
  logic [BC_W-1:0]  r_bit;
  logic [PH_W-1:0]  r_phase;
  logic             r_sck, r_ws, r_sd, r_busy, r_overrun;

  logic [OUT_W-1:0] w_scaled;
  logic [PH_W-1:0]  w_ph_next;
  logic             w_edge, w_last, w_load, w_drop;

  fir_tx_scaler #(.N(N), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scaler (
    .i_y    (y_in),
    .o_word (w_scaled)
  );

  assign w_edge    = clk_d & ~r_clk_d_q & ena;
  assign w_last    = (r_state == fir_tx_pkg::SHIFT) && (r_bit == '0) && (r_phase == PH_LAST);
  assign w_load    = w_edge && ((r_state == fir_tx_pkg::IDLE) || w_last);
  assign w_drop    = w_edge && (r_state == fir_tx_pkg::SHIFT) && !w_last;
  assign w_ph_next = r_phase + PH_W'(1);

  // Outputs are registered alongside the state so they change cleanly on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= fir_tx_pkg::IDLE;
      r_clk_d_q <= 1'b0;
      r_sr      <= '0;
      r_bit     <= '0;
      r_phase   <= '0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b0;
      r_sd      <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_clk_d_q <= clk_d;

      if (w_drop)       r_overrun <= 1'b1;
      else if (ovr_clr) r_overrun <= 1'b0;

      if (w_load) begin
        r_state <= fir_tx_pkg::SHIFT;
        r_sr    <= w_scaled;
        r_bit   <= BIT_FIRST;
        r_phase <= '0;
        r_busy  <= 1'b1;
        r_ws    <= 1'b1;
        r_sd    <= w_scaled[OUT_W-1];
        r_sck   <= 1'b0;
      end else if (r_state == fir_tx_pkg::SHIFT) begin
        if (w_last) begin
          r_state <= fir_tx_pkg::IDLE;
          r_phase <= '0;
          r_busy  <= 1'b0;
          r_ws    <= 1'b0;
          r_sd    <= 1'b0;
          r_sck   <= 1'b0;
        end else if (r_phase == PH_LAST) begin
          r_phase <= '0;
          r_sr    <= {r_sr[OUT_W-2:0], 1'b0};
          r_bit   <= r_bit - BC_W'(1);
          r_sd    <= r_sr[OUT_W-2];
          r_ws    <= 1'b0;
          r_sck   <= 1'b0;
        end else begin
          r_phase <= w_ph_next;
          r_sck   <= (w_ph_next >= PH_HALF);
        end
      end
    end
  end

  assign sck     = r_sck;
  assign ws      = r_ws;
  assign sd      = r_sd;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed self-checking bench for fir_sample_tx: table of sample/word pairs
// plus hand-written overrun, back-to-back, reset and enable sequences.
module tb_fir_sample_tx;
  localparam int N       = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 10;
  localparam int BIT_DIV = 4;
  localparam int FRAME   = OUT_W * BIT_DIV;
  localparam int NVEC    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic clk_d = 1'b0;
  logic ovr_clr = 1'b0;
  logic signed [N-1:0] y_in = '0;
  logic sck, ws, sd, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [N-1:0]     y;
    logic [OUT_W-1:0] exp;
  } vec_t;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  fir_sample_tx #(.N(N), .OUT_W(OUT_W), .SHIFT(SHIFT), .BIT_DIV(BIT_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clk_d   (clk_d),
    .y_in    (y_in),
    .ovr_clr (ovr_clr),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Raise clk_d for one cycle with sample y, then scramble y_in.
  task automatic start_frame(input logic [N-1:0] y);
    @(negedge clk);
    y_in  = y;
    clk_d = 1'b1;
    @(negedge clk);
    clk_d = 1'b0;
    y_in  = 32'h5A5A_5A5A;
  endtask

  // Called at the negedge of the first frame cycle; returns one cycle after the frame.
  task automatic watch_frame(input string name, input logic [OUT_W-1:0] exp,
                             input int pulse_at, input logic [N-1:0] pulse_y);
    logic [OUT_W-1:0] word = '0;
    int bad_ws = 0;
    int bad_sck = 0;
    int bad_busy = 0;
    logic e_ws, e_sck;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (i == pulse_at + 1) clk_d = 1'b0;
      e_ws  = (i < BIT_DIV);
      e_sck = ((i % BIT_DIV) >= BIT_DIV / 2);
      if (busy !== 1'b1) bad_busy++;
      if (ws !== e_ws)   bad_ws++;
      if (sck !== e_sck) bad_sck++;
      if ((i % BIT_DIV) == BIT_DIV / 2) word = {word[OUT_W-2:0], sd};
      if (i == pulse_at) begin
        clk_d = 1'b1;
        y_in  = pulse_y;
      end
    end
    check({name, "_word"}, 32'(word), 32'(exp));
    check({name, "_busy_bad_cycles"}, bad_busy, 0);
    check({name, "_ws_bad_cycles"}, bad_ws, 0);
    check({name, "_sck_bad_cycles"}, bad_sck, 0);
    @(negedge clk);
    if (clk_d) clk_d = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    vecs[0] = '{32'd193000, 16'h00BC};
    vecs[1] = '{32'd376000, 16'h016F};
    vecs[2] = '{32'd0, 16'h0000};
    vecs[3] = '{-32'sd1000, 16'hFFFF};
    vecs[4] = '{-32'sd193000, 16'hFF43};
    vecs[5] = '{32'h0012_3456, 16'h048D};
`ifdef FIR_SAMPLE_TX_SATURATE_EN
    vecs[6] = '{32'h7FFF_FFFF, 16'h7FFF};
    vecs[7] = '{32'h8000_0000, 16'h8000};
    vecs[8] = '{32'h0400_0000, 16'h7FFF};
`else
    vecs[6] = '{32'h7FFF_FFFF, 16'hFFFF};
    vecs[7] = '{32'h8000_0000, 16'h0000};
    vecs[8] = '{32'h0400_0000, 16'h0000};
`endif

    // Reset held two cycles while clk_d toggles.
    @(negedge clk);
    clk_d = 1'b1;
    @(negedge clk);
    check("reset_outputs_c1", {27'd0, sck, ws, sd, busy, overrun}, 32'd0);
    clk_d = 1'b0;
    @(negedge clk);
    check("reset_outputs_c2", {27'd0, sck, ws, sd, busy, overrun}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {31'd0, busy}, 32'd0);

    // Table: single frames, including the impulse-response sequence.
    for (int v = 0; v < NVEC; v++) begin
      start_frame(vecs[v].y);
      watch_frame($sformatf("vec%0d", v), vecs[v].exp, -1, '0);
      check($sformatf("vec%0d_idle_after", v), {31'd0, busy}, 32'd0);
    end
    check("no_overrun_after_table", {31'd0, overrun}, 32'd0);

    // Second edge 20 cycles into a frame is dropped and flags overrun.
    start_frame(32'd193000);
    watch_frame("ovr_frame", 16'h00BC, 20, 32'd376000);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_no_new_frame", {31'd0, busy}, 32'd0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Edge on the last frame cycle chains the next frame with no gap.
    start_frame(32'd193000);
    watch_frame("b2b_a", 16'h00BC, FRAME - 1, 32'd376000);
    watch_frame("b2b_b", 16'h016F, -1, '0);
    check("b2b_idle_after", {31'd0, busy}, 32'd0);
    check("b2b_no_overrun", {31'd0, overrun}, 32'd0);

    // Reset mid-frame while sd is high.
    start_frame(-32'sd1000);
    repeat (10) @(negedge clk);
    check("midframe_sd_high", {31'd0, sd}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset", {28'd0, busy, sd, sck, ws}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midframe_reset_stays_idle", {31'd0, busy}, 32'd0);

    // Edges ignored while disabled.
    ena = 1'b0;
    start_frame(32'd193000);
    busy_cnt = 0;
    for (int i = 0; i < FRAME + 6; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("ena_low_no_frame", busy_cnt, 0);
    ena = 1'b1;

    // Enabled again, a frame runs normally.
    start_frame(32'd376000);
    watch_frame("ena_restored", 16'h016F, -1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_tx.md
# fir_sample_tx

Serial transmitter for filtered samples: captures one signed `y_out` word from `fir_n` on every rising edge of the sample strobe `clk_d`, scales it to an output word width, and shifts it out MSB-first on a bit clock with a one-bit frame sync. It sits on the output side of the filter chain and is the counterpart to the sample-rate capture side feeding `x_in`. Everything runs on the system clock `clk`; `clk_d` is treated as a data input and edge-detected.

## Interface
- `N`, 32, width of the incoming signed sample (matches `fir_n` `N`)
- `OUT_W`, 16, transmitted word width; 2 ≤ `OUT_W` ≤ `N`
- `SHIFT`, 10, arithmetic right shift applied before width reduction; 0 ≤ `SHIFT` < `N`
- `BIT_DIV`, 4, `clk` cycles per serial bit; even, ≥ 2

- `clk`  input  1  system clock; all logic on its rising edge
- `rst`  input  1  synchronous, active-high reset
- `ena`  input  1  when low, new sample edges are ignored; a frame in progress completes
- `clk_d`  input  1  sample strobe from `clk_divider`; rising edge requests a capture
- `y_in`  input  `N`  signed sample, connected to `fir_n` `y_out`
- `ovr_clr`  input  1  clears `overrun`
- `sck`  output  1  serial bit clock
- `ws`  output  1  frame sync, high during the MSB bit period only
- `sd`  output  1  serial data, MSB first
- `busy`  output  1  high while a frame is being shifted
- `overrun`  output  1  sticky; a sample edge arrived while unable to start a frame

## Operation
- Edge detect: `clk_d_q` registers `clk_d`; `edge = clk_d & ~clk_d_q & ena`.
- Scaling: `s = y_in >>> SHIFT` (sign-preserving), then reduced to `OUT_W` bits (see Configuration).
- FSM states: `IDLE`, `SHIFT`.
  - `IDLE`: on `edge`, load scaled word into shift register, bit counter = `OUT_W-1`, phase counter = 0, go `SHIFT`.
  - `SHIFT`: phase counter counts 0..`BIT_DIV-1`; at `BIT_DIV-1` shift register moves left one bit and bit counter decrements. When bit counter = 0 and phase = `BIT_DIV-1` (last frame cycle): if `edge`, reload and stay in `SHIFT` (back-to-back frame, no gap); else go `IDLE`.
  - `edge` in `SHIFT` on any cycle except the last frame cycle: sample dropped, `overrun` set.
- `sd` = shift register MSB in `SHIFT`, 0 in `IDLE`.
- `sck` = 0 for phase < `BIT_DIV/2`, 1 otherwise, in `SHIFT`; 0 in `IDLE`. `sd` changes only at phase 0; receiver samples on `sck` rise.
- `ws` = 1 while bit counter = `OUT_W-1` in `SHIFT`.
- `overrun`: set by drop, cleared by `ovr_clr`; simultaneous set and clear -> set wins.
- Reset mid-frame: frame abandoned, all state to reset values on the next `clk` edge.

## Timing
- Reset values: `sck`=0, `ws`=0, `sd`=0, `busy`=0, `overrun`=0, state `IDLE`, `clk_d_q`=0.
- `clk_d` seen high in cycle k with `clk_d_q`=0 -> `busy`, `ws`, `sd`=MSB valid from cycle k+1.
- Frame length exactly `OUT_W*BIT_DIV` cycles (defaults: 64); `busy` high for exactly that span.
- `y_in` sampled only in the capture cycle; later changes do not affect the frame.
- Integration requirement: `OUT_W*BIT_DIV` ≤ `CLK_HZ/DESIRED_HZ` (defaults 64 ≤ 250), else `overrun` fires every sample.

## Configuration
- `FIR_SAMPLE_TX_SATURATE_EN` defined: `s` clamped to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1] before taking the low `OUT_W` bits.
- Not defined: low `OUT_W` bits of `s` taken directly (wrap-around truncation); no clamp logic synthesized.

## Structure
- Package `fir_tx_pkg`: FSM state enum (`IDLE`, `SHIFT`), counter width localparams derived from `OUT_W` and `BIT_DIV`.
- One sub-module `fir_tx_scaler`: combinational shift plus saturate/truncate, parameterized by `N`, `OUT_W`, `SHIFT`; holds the macro guard.

## Test plan
- Reset asserted 2 cycles with `clk_d` toggling -> all outputs 0, no frame starts.
- `y_in`=193000 at `clk_d` rise -> 64-cycle frame, `sd` bits = 0x00BC MSB first, `ws` high for first 4 cycles only, `sck` 2 low/2 high per bit.
- Impulse response of `fir_n` (b = 193,376,376,193; x=1000) -> successive frames 0x00BC, 0x016F, 0x016F, 0x00BC, then 0x0000.
- `y_in`=0x7FFFFFFF -> 0x7FFF with `FIR_SAMPLE_TX_SATURATE_EN`, 0xFFFF without; `y_in`=-1000 -> 0xFFFF both builds.
- Second `clk_d` rise 20 cycles into a frame -> `overrun`=1, current frame unchanged; `ovr_clr` pulse -> 0; rise on last frame cycle -> next frame starts with no gap, no overrun.
- `rst` pulsed mid-frame -> next cycle `busy`=`sd`=`sck`=`ws`=0; `ena`=0 -> edges ignored, no frames.
